// File: rtl/adc_scan_ctrl.sv
// Multi-channel ADC scan controller: settle, average and report each masked channel.
// Define ADC_SCAN_THRESH_EN to add the sticky per-channel limit alarm (thresh/alarm ports).
module adc_scan_ctrl #(
  parameter int ADC_WIDTH      = 8,
  parameter int NUM_CH         = 4,
  parameter int SETTLE_SAMPLES = 2,
  parameter int AVG_BITS       = 2,
  localparam int SEL_W         = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_CH-1:0]    ch_mask,
  input  logic                 continuous,
  input  logic                 sample_rdy,
  input  logic [ADC_WIDTH-1:0] digital_in,
  output logic [SEL_W-1:0]     mux_sel,
  output logic                 busy,
  output logic                 result_valid,
  output logic [SEL_W-1:0]     result_ch,
  output logic [ADC_WIDTH-1:0] result_data,
`ifdef ADC_SCAN_THRESH_EN
  input  logic [ADC_WIDTH-1:0] thresh,
  output logic [NUM_CH-1:0]    alarm,
`endif
  output logic                 done
);

  localparam int ACC_W = ADC_WIDTH + AVG_BITS;
  localparam int CNT_W = 7;
  localparam int AVG_N = 1 << AVG_BITS;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    SETTLE,
    ACCUM,
    RESULT
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [SEL_W-1:0]   r_mux_sel, w_mux_nxt;
  logic [NUM_CH-1:0]  r_mask, w_mask_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [ACC_W-1:0]   r_acc, w_acc_nxt;
  logic               r_done, w_done_nxt;

  logic [SEL_W-1:0]   w_lo;
  logic [SEL_W-1:0]   w_hi;
  logic               w_has_hi;

  // Lowest enabled channel of the live mask input.
  always_comb begin
    w_lo = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) w_lo = SEL_W'(i);
    end
  end

  // Next enabled channel above the current one in the latched mask.
  always_comb begin
    w_hi     = '0;
    w_has_hi = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (r_mask[i] && (i > int'(r_mux_sel))) begin
        w_hi     = SEL_W'(i);
        w_has_hi = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mux_sel <= '0;
      r_mask    <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mux_sel <= w_mux_nxt;
      r_mask    <= w_mask_nxt;
      r_cnt     <= w_cnt_nxt;
      r_acc     <= w_acc_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mux_nxt   = r_mux_sel;
    w_mask_nxt  = r_mask;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start && (|ch_mask)) begin
          w_mask_nxt  = ch_mask;
          w_mux_nxt   = w_lo;
          w_state_nxt = SELECT;
        end
      end
      SELECT: begin
        w_cnt_nxt   = '0;
        w_acc_nxt   = '0;
        w_state_nxt = (SETTLE_SAMPLES == 0) ? ACCUM : SETTLE;
      end
      SETTLE: begin
        if (sample_rdy) begin
          if (r_cnt == CNT_W'(SETTLE_SAMPLES - 1)) begin
            w_cnt_nxt   = '0;
            w_acc_nxt   = '0;
            w_state_nxt = ACCUM;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      ACCUM: begin
        if (sample_rdy) begin
          w_acc_nxt = r_acc + ACC_W'(digital_in);
          if (r_cnt == CNT_W'(AVG_N - 1)) begin
            w_state_nxt = RESULT;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      RESULT: begin
        if (w_has_hi) begin
          w_mux_nxt   = w_hi;
          w_state_nxt = SELECT;
        end else if (continuous && (|ch_mask)) begin
          w_mask_nxt  = ch_mask;
          w_mux_nxt   = w_lo;
          w_state_nxt = SELECT;
        end else begin
          // A continuous re-latch of an empty mask also ends the sweep.
          if (continuous) w_mask_nxt = ch_mask;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign mux_sel      = r_mux_sel;
  assign busy         = (r_state != IDLE);
  assign result_valid = (r_state == RESULT);
  assign result_ch    = result_valid ? r_mux_sel : '0;
  assign result_data  = result_valid ? ADC_WIDTH'(r_acc >> AVG_BITS) : '0;
  assign done         = r_done;

`ifdef ADC_SCAN_THRESH_EN
  logic [NUM_CH-1:0] r_alarm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alarm <= '0;
    end else if (result_valid && (result_data > thresh)) begin
      r_alarm[r_mux_sel] <= 1'b1;
    end
  end

  assign alarm = r_alarm;
`endif

endmodule
